// File: rtl/relu_backward_seq.sv
// Streams a gradient tensor through a WIDTH-lane ReLU backward layer one chunk per cycle.
// Optional stall counter output enabled by defining RELU_BWD_SEQ_PERF_EN.
module relu_backward_seq #(
    parameter int WIDTH         = 8,
    parameter int LAYER_LATENCY = 1,
    parameter int FIFO_DEPTH    = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_elems,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data [WIDTH-1:0],
    output logic [31:0]      lyr_in_vec [WIDTH-1:0],
    input  logic [31:0]      lyr_out_vec [WIDTH-1:0],
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data [WIDTH-1:0],
    output logic [WIDTH-1:0] out_mask,
    output logic             out_last,
    output logic             busy,
    output logic             done
`ifdef RELU_BWD_SEQ_PERF_EN
    ,
    output logic [31:0]      stall_cycles
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_F = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   chunks_left_q, chunks_left_d;
    logic [CNT_W-1:0]   rem_q, rem_d;

    logic [LAYER_LATENCY-1:0] sr_valid_q;
    logic [LAYER_LATENCY-1:0] sr_last_q;
    logic [WIDTH-1:0]         sr_mask_q [LAYER_LATENCY-1:0];

    logic [31:0]            fifo_data_q [FIFO_DEPTH-1:0][WIDTH-1:0];
    logic [WIDTH-1:0]       fifo_mask_q [FIFO_DEPTH-1:0];
    logic [FIFO_DEPTH-1:0]  fifo_last_q;
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_F-1:0]       fifo_count_q;

    logic [CNT_F-1:0]   inflight;
    logic [CNT_F-1:0]   credit;
    logic               accept;
    logic               is_last_chunk;
    logic [WIDTH-1:0]   chunk_mask;
    logic               fifo_push;
    logic               fifo_pop;
    logic [CNT_W:0]     elems_rounded;
    logic [CNT_W-1:0]   chunks_total;
    logic [CNT_W-1:0]   rem_new;

    assign elems_rounded = {1'b0, num_elems} + (CNT_W+1)'(WIDTH - 1);
    assign chunks_total  = CNT_W'(elems_rounded / (CNT_W+1)'(WIDTH));
    assign rem_new       = num_elems % CNT_W'(WIDTH);

    always_comb begin
        inflight = '0;
        for (int k = 0; k < LAYER_LATENCY; k++) begin
            inflight = inflight + CNT_F'(sr_valid_q[k]);
        end
    end

    // Credits cover every chunk that will land in the FIFO, so a tail write never overflows.
    assign credit        = CNT_F'(FIFO_DEPTH) - fifo_count_q - inflight;
    assign in_ready      = (state_q == S_RUN) && (chunks_left_q != '0) && (credit != '0);
    assign accept        = in_valid && in_ready;
    assign is_last_chunk = (chunks_left_q == CNT_W'(1));

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            chunk_mask[i] = !is_last_chunk || (rem_q == '0) || (CNT_W'(i) < rem_q);
            lyr_in_vec[i] = (accept && chunk_mask[i]) ? in_data[i] : 32'h0;
        end
    end

    assign fifo_push = sr_valid_q[LAYER_LATENCY-1];
    assign out_valid = (fifo_count_q != '0);
    assign fifo_pop  = out_valid && out_ready;
    assign out_mask  = out_valid ? fifo_mask_q[rd_ptr_q] : '0;
    assign out_last  = out_valid && fifo_last_q[rd_ptr_q];

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            out_data[i] = out_valid ? fifo_data_q[rd_ptr_q][i] : 32'h0;
        end
    end

    assign busy = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done = (state_q == S_DONE);

    always_comb begin
        state_d       = state_q;
        chunks_left_d = chunks_left_q;
        rem_d         = rem_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    chunks_left_d = chunks_total;
                    rem_d         = rem_new;
                    state_d       = (num_elems == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (accept) begin
                    chunks_left_d = chunks_left_q - CNT_W'(1);
                    if (is_last_chunk) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (fifo_pop && out_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            chunks_left_q <= '0;
            rem_q         <= '0;
        end else begin
            state_q       <= state_d;
            chunks_left_q <= chunks_left_d;
            rem_q         <= rem_d;
        end
    end

    // Metadata travels alongside the layer so it meets the matching out_vec at the tail.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_valid_q <= '0;
            sr_last_q  <= '0;
            for (int k = 0; k < LAYER_LATENCY; k++) begin
                sr_mask_q[k] <= '0;
            end
        end else begin
            sr_valid_q[0] <= accept;
            sr_last_q[0]  <= accept && is_last_chunk;
            sr_mask_q[0]  <= accept ? chunk_mask : '0;
            for (int k = 1; k < LAYER_LATENCY; k++) begin
                sr_valid_q[k] <= sr_valid_q[k-1];
                sr_last_q[k]  <= sr_last_q[k-1];
                sr_mask_q[k]  <= sr_mask_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            for (int i = 0; i < WIDTH; i++) begin
                fifo_data_q[wr_ptr_q][i] <= lyr_out_vec[i];
            end
            fifo_mask_q[wr_ptr_q] <= sr_mask_q[LAYER_LATENCY-1];
            fifo_last_q[wr_ptr_q] <= sr_last_q[LAYER_LATENCY-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count_q <= fifo_count_q + CNT_F'(1);
                2'b01:   fifo_count_q <= fifo_count_q - CNT_F'(1);
                default: fifo_count_q <= fifo_count_q;
            endcase
        end
    end

`ifdef RELU_BWD_SEQ_PERF_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == S_IDLE) && start) begin
            stall_d = '0;
        end else if (busy && out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule
